// File: rtl/cic_iq_gain_scheduler.sv
// cic_iq_gain_scheduler: post-CIC I/Q gain stage sharing one signed multiplier between
// the real and imag channels, with round-half-up, saturation and aligned pair output.
module cic_iq_gain_scheduler #(
    parameter int DIN_W     = 23,
    parameter int DIN_FRAC  = 15,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 15,
    parameter int DOUT_W    = 16,
    parameter int DOUT_FRAC = 14,
    parameter int MULT_LAT  = 2,
    parameter logic [GAIN_W-1:0] GAIN_INIT = 16'h7FFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIN_W-1:0]  real_din,
    input  logic              real_valid,
    input  logic [DIN_W-1:0]  imag_din,
    input  logic              imag_valid,
    input  logic [GAIN_W-1:0] gain,
    input  logic              gain_ld,
    input  logic              overrun_clr,
    output logic [DOUT_W-1:0] real_dout,
    output logic [DOUT_W-1:0] imag_dout,
    output logic              dout_valid,
    output logic              overrun,
    output logic              busy
);
    localparam int PW = DIN_W + GAIN_W;
    localparam int SH = DIN_FRAC + GAIN_FRAC - DOUT_FRAC;
    localparam logic signed [PW:0] HALF = 1 <<< (SH - 1);
    localparam logic [DOUT_W-1:0] MAXV = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic [DOUT_W-1:0] MINV = {1'b1, {(DOUT_W-1){1'b0}}};

    typedef enum logic {IDLE, ISSUE_Q} state_t;
    state_t state, state_nx;

    logic issue, clr;
    logic real_cap, imag_cap, real_drop, imag_drop;
    logic real_full, imag_full, op_v, op_q;
    logic signed [DIN_W-1:0]  real_hold, imag_hold, op;
    logic signed [GAIN_W-1:0] gain_pend, gain_act;
    logic signed [PW-1:0]     prod [MULT_LAT];
    logic [MULT_LAT-1:0]      prod_v, prod_q;
    logic signed [PW:0]       rnd, shf;
    logic [DOUT_W-1:0]        res, real_side;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb state_nx = (state == IDLE && real_full && imag_full) ? ISSUE_Q : IDLE;

    always_comb begin
        issue = state == IDLE && real_full && imag_full;
        clr   = state == ISSUE_Q;
    end

    // The clearing edge frees the slot, so a sample arriving then is kept, not dropped.
    assign real_cap  = real_valid && (!real_full || clr);
    assign imag_cap  = imag_valid && (!imag_full || clr);
    assign real_drop = real_valid && real_full && !clr;
    assign imag_drop = imag_valid && imag_full && !clr;

    assign rnd  = prod[MULT_LAT-1] + HALF;
    assign shf  = rnd >>> SH;
    assign res  = (&shf[PW:DOUT_W-1] || ~|shf[PW:DOUT_W-1]) ? shf[DOUT_W-1:0] : (shf[PW] ? MINV : MAXV);
    assign busy = real_full | imag_full | op_v | (|prod_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            real_hold   <= '0;
            imag_hold   <= '0;
            real_full   <= 1'b0;
            imag_full   <= 1'b0;
            overrun     <= 1'b0;
            gain_pend   <= GAIN_INIT;
            gain_act    <= GAIN_INIT;
            op          <= '0;
            op_v        <= 1'b0;
            op_q        <= 1'b0;
            prod_v      <= '0;
            prod_q      <= '0;
            for (int i = 0; i < MULT_LAT; i++) prod[i] <= '0;
            real_side   <= '0;
            real_dout   <= '0;
            imag_dout   <= '0;
            dout_valid  <= 1'b0;
        end else begin
            if (real_cap) real_hold <= real_din;
            if (imag_cap) imag_hold <= imag_din;
            real_full <= real_cap | (real_full & ~clr);
            imag_full <= imag_cap | (imag_full & ~clr);
            overrun   <= real_drop | imag_drop | (overrun & ~overrun_clr);
            if (gain_ld) gain_pend <= gain;
            // Gain only changes between pairs, never between the R and Q halves.
            if (state == IDLE && !issue) gain_act <= gain_pend;
            if (issue || clr) op <= issue ? real_hold : imag_hold;
            op_v      <= issue | clr;
            op_q      <= clr;
            prod[0]   <= PW'(op) * PW'(gain_act);
            prod_v[0] <= op_v;
            prod_q[0] <= op_q;
            for (int i = 1; i < MULT_LAT; i++) begin
                prod[i]   <= prod[i-1];
                prod_v[i] <= prod_v[i-1];
                prod_q[i] <= prod_q[i-1];
            end
            if (prod_v[MULT_LAT-1] && !prod_q[MULT_LAT-1]) real_side <= res;
            if (prod_v[MULT_LAT-1] && prod_q[MULT_LAT-1]) begin
                imag_dout <= res;
                real_dout <= real_side;
            end
            dout_valid <= prod_v[MULT_LAT-1] & prod_q[MULT_LAT-1];
        end
    end
endmodule
